// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter for the shared byte-wide UART transmitter, one whole message per grant.
// Define UART_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 wins every tie.
module uart_tx_arbiter #(
    parameter int BYTE_GAP = 255,
    parameter int LEN_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic [7:0]       data0,
    input  logic [7:0]       data1,
    output logic             ack0,
    output logic             ack1,
    output logic             done0,
    output logic             done1,
    output logic [7:0]       txdata,
    output logic             wrsig,
    output logic             busy,
    output logic             grant
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        GAP,
        DONE
    } state_t;

    localparam logic [15:0] GAP_LAST = 16'(BYTE_GAP - 2);

`ifdef UART_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    state_t           state;
    state_t           next_state;
    logic             next_grant;
    logic [LEN_W-1:0] remain;
    logic [15:0]      gap_cnt;
    logic             last_grant;
    logic             aborted;

    logic             req_g;
    logic [LEN_W-1:0] len_g;
    logic [7:0]       data_g;
    logic             gap_term;
    logic             remain_zero;
    logic             abort_now;
    logic             tie_pick;

    assign req_g       = grant ? req1  : req0;
    assign len_g       = grant ? len1  : len0;
    assign data_g      = grant ? data1 : data0;
    assign gap_term    = (gap_cnt == GAP_LAST);
    assign remain_zero = (remain == '0);
    assign abort_now   = (state == GAP) && gap_term && !remain_zero && !req_g;

    // last_grant only steers ties in the round-robin build; RR_EN folds it away otherwise
    assign tie_pick    = RR_EN & ~last_grant;

    always_comb begin
        next_state = state;
        next_grant = grant;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    next_grant = tie_pick;
                    next_state = LOAD;
                end else if (req0) begin
                    next_grant = 1'b0;
                    next_state = LOAD;
                end else if (req1) begin
                    next_grant = 1'b1;
                    next_state = LOAD;
                end
            end
            LOAD:    next_state = (len_g == '0) ? DONE : SEND;
            SEND:    next_state = GAP;
            GAP: begin
                if (gap_term) begin
                    next_state = (remain_zero || !req_g) ? DONE : SEND;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // busy stays up through the cycle in which done is visible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            remain     <= '0;
            gap_cnt    <= '0;
            aborted    <= 1'b0;
            txdata     <= 8'h00;
            wrsig      <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (state != IDLE) || (next_state != IDLE);
            wrsig <= 1'b0;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    grant <= next_grant;
                end
                LOAD: begin
                    remain  <= len_g;
                    aborted <= 1'b0;
                end
                SEND: begin
                    txdata  <= data_g;
                    wrsig   <= 1'b1;
                    ack0    <= ~grant;
                    ack1    <= grant;
                    remain  <= remain - LEN_W'(1);
                    gap_cnt <= 16'd0;
                end
                GAP: begin
                    if (!gap_term) begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                    if (abort_now) begin
                        aborted <= 1'b1;
                    end
                end
                DONE: begin
                    done0      <= ~aborted & ~grant;
                    done1      <= ~aborted & grant;
                    last_grant <= grant;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
